// File: rtl/clk_div_prog.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_prog
// Description : Programmable integer clock divider (ratio 2..2^DIV_W-1, odd or
//               even) with bypass for ratios 0/1, glitch-free ratio changes at
//               period boundaries, clean enable, period-start tick and ratio
//               readback.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_prog #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_div_ratio,
    output logic             o_clk,
    output logic             o_tick,
    output logic [DIV_W-1:0] o_ratio
);

    localparam int CW = DIV_W + 1;

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_ratio;
    logic             r_div;
    logic             r_tick;
    logic             r_en_n;
    logic             r_en_prev;

    logic [CW-1:0]    w_half;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_bypass;
    logic             w_last;
    logic             w_boundary;
    logic             w_req_div;

    // Half-period and counter increment carry one extra bit so N = 2^DIV_W-1
    // cannot wrap.
    assign w_half     = ({1'b0, r_ratio} + CW'(1)) >> 1;
    assign w_cnt_nxt  = {1'b0, r_cnt} + CW'(1);
    assign w_bypass   = (r_ratio < DIV_W'(2));
    assign w_last     = (r_cnt == (r_ratio - DIV_W'(1)));
    assign w_boundary = w_bypass | w_last | ~r_en_prev;
    assign w_req_div  = (i_div_ratio >= DIV_W'(2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_ratio   <= '0;
            r_div     <= 1'b0;
            r_tick    <= 1'b0;
            r_en_prev <= 1'b0;
        end else if (!i_en) begin
            r_cnt     <= '0;
            r_div     <= 1'b0;
            r_tick    <= 1'b0;
            r_en_prev <= 1'b0;
        end else begin
            r_en_prev <= 1'b1;
            if (w_boundary) begin
                r_ratio <= i_div_ratio;
                r_cnt   <= '0;
                r_tick  <= 1'b1;
                r_div   <= w_req_div;
            end else begin
                r_cnt   <= w_cnt_nxt[DIV_W-1:0];
                r_tick  <= 1'b0;
                r_div   <= (w_cnt_nxt < w_half);
            end
        end
    end

    // Bypass gate enable changes only while clk is low, so the gate never chops a pulse.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_en_n <= 1'b0;
        end else begin
            r_en_n <= i_en;
        end
    end

    assign o_clk   = w_bypass ? (clk & r_en_n) : r_div;
    assign o_tick  = r_tick;
    assign o_ratio = r_ratio;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_prog.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_div_prog
// Description : Self-checking bench for clk_div_prog; per-period scoreboard
//               plus direct checks for reset, enable and glitch behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_prog;

    localparam int DIV_W = 8;

    logic             clk;
    logic             rst;
    logic             i_en;
    logic [DIV_W-1:0] i_div_ratio;
    logic             o_clk;
    logic             o_tick;
    logic [DIV_W-1:0] o_ratio;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int ratio;
        int high;
        int len;
    } exp_t;

    typedef struct {
        int next;
        int dly;
        int eratio;
        int ehigh;
        int elen;
    } vec_t;

    exp_t sb[$];

    // {next ratio, cycles before changing it, expected ratio/high/len of the current period}
    vec_t tbl [15] = '{
        '{8,   0, 8,   4,   8},
        '{3,   2, 8,   4,   8},
        '{3,   0, 3,   2,   3},
        '{5,   0, 3,   2,   3},
        '{5,   0, 5,   3,   5},
        '{255, 0, 5,   3,   5},
        '{2,   0, 255, 128, 255},
        '{1,   0, 2,   1,   2},
        '{0,   0, 1,   1,   1},
        '{0,   0, 0,   1,   1},
        '{4,   0, 0,   1,   1},
        '{1,   0, 4,   2,   4},
        '{4,   0, 1,   1,   1},
        '{6,   0, 4,   2,   4},
        '{6,   0, 6,   3,   6}
    };

    clk_div_prog #(.DIV_W(DIV_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_en       (i_en),
        .i_div_ratio(i_div_ratio),
        .o_clk      (o_clk),
        .o_tick     (o_tick),
        .o_ratio    (o_ratio)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_tick();
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!o_tick && n < 400);
        check("tick_seen", int'(o_tick), 1);
    endtask

    task automatic step(input vec_t v);
        sb.push_back('{v.eratio, v.ehigh, v.elen});
        for (int i = 0; i < v.dly; i++) begin
            @(posedge clk);
            #1;
        end
        if (v.dly > 0) check("ratio_hold_mid_period", int'(o_ratio), v.eratio);
        i_div_ratio = DIV_W'(v.next);
        wait_tick();
    endtask

    // Period monitor: closes a period at each tick and compares it with the scoreboard.
    initial begin
        bit   open  = 1'b0;
        bit   dirty = 1'b0;
        int   p_len = 0;
        int   p_high = 0;
        int   p_ratio = 0;
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                open = 1'b0;
            end else begin
                if (o_tick) begin
                    if (open && !dirty) begin
                        if (sb.size() == 0) begin
                            check("sb_unexpected_period", p_len, 0);
                        end else begin
                            e = sb.pop_front();
                            check("period_ratio", p_ratio, e.ratio);
                            check("period_high", p_high, e.high);
                            check("period_len", p_len, e.len);
                        end
                    end
                    open    = 1'b1;
                    dirty   = 1'b0;
                    p_len   = 0;
                    p_high  = 0;
                    p_ratio = int'(o_ratio);
                end
                if (open) begin
                    p_len++;
                    if (o_clk) p_high++;
                    if (!i_en) dirty = 1'b1;
                end
            end
        end
    end

    // Minimum o_clk pulse width while the glitch watch is on.
    bit  glitch_on = 1'b0;
    bit  have_last = 1'b0;
    time last_t    = 0;
    time min_w     = 1000000;
    always @(o_clk) begin
        if (glitch_on) begin
            if (have_last && ($time - last_t) > 0 && ($time - last_t) < min_w)
                min_w = $time - last_t;
            last_t    = $time;
            have_last = 1'b1;
        end else begin
            have_last = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        i_en        = 1'b0;
        i_div_ratio = 8'd8;
        #2;
        check("reset_o_clk", int'(o_clk), 0);
        check("reset_o_tick", int'(o_tick), 0);
        check("reset_o_ratio", int'(o_ratio), 0);
        #10;
        rst = 1'b0;
        @(negedge clk);
        i_en = 1'b1;
        wait_tick();
        check("first_tick_o_clk", int'(o_clk), 1);
        check("first_tick_ratio", int'(o_ratio), 8);

        glitch_on = 1'b1;
        foreach (tbl[i]) step(tbl[i]);
        glitch_on = 1'b0;
        check("min_pulse_width_ge_half_clk", int'(min_w >= 5), 1);

        // Enable drop in the high phase of an N=6 period.
        @(negedge clk);
        i_en = 1'b0;
        @(posedge clk);
        #1;
        check("en_drop_o_clk", int'(o_clk), 0);
        check("en_drop_o_tick", int'(o_tick), 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        check("disabled_o_clk", int'(o_clk), 0);
        check("disabled_ratio_hold", int'(o_ratio), 6);
        @(negedge clk);
        i_en = 1'b1;
        @(posedge clk);
        #1;
        check("reenable_o_clk", int'(o_clk), 1);
        check("reenable_o_tick", int'(o_tick), 1);
        step('{6, 0, 6, 3, 6});
        step('{7, 0, 6, 3, 6});

        // Asynchronous reset in the middle of an N=7 period.
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_o_clk", int'(o_clk), 0);
        check("async_rst_o_tick", int'(o_tick), 0);
        check("async_rst_o_ratio", int'(o_ratio), 0);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_o_clk", int'(o_clk), 1);
        check("post_rst_o_tick", int'(o_tick), 1);
        check("post_rst_o_ratio", int'(o_ratio), 7);
        step('{7, 0, 7, 4, 7});
        step('{7, 0, 7, 4, 7});

        @(posedge clk);
        @(posedge clk);
        #1;
        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
Parametrised programmable integer clock divider: the next generation of the system clock divider, feeding the UART baud logic and other slow domains. It supports any ratio from 2 to 2^DIV_W-1, odd or even. Ratios 0/1 select bypass. New ratios apply only at a period boundary, so ratio changes never glitch. It adds an enable with clean stop/start, a one-cycle period-start tick, and readback of the applied ratio.

Parameters:
DIV_W, 8, width of the ratio input and the internal counter. Legal range is 2..16.

Ports:
clk  input  1  source clock; all sequential logic is on the rising edge unless stated otherwise
rst  input  1  asynchronous reset, active-high
i_en  input  1  divider enable, synchronous
i_div_ratio  input  DIV_W  requested ratio N; 0 and 1 select bypass
o_clk  output  1  divided clock (or gated clk in bypass)
o_tick  output  1  registered, 1 clk cycle wide, marks the start of each o_clk period
o_ratio  output  DIV_W  ratio currently applied (ratio_q)

Behaviour:
- State: cnt[DIV_W-1:0], ratio_q[DIV_W-1:0], div_q, tick_q, en_n (i_en captured on the clk falling edge; used only for bypass gating).
- Reset (async, rst=1): cnt=0, ratio_q=0, div_q=0, tick_q=0, en_n=0. Resulting outputs: o_clk=0, o_tick=0, o_ratio=0. All take effect immediately, independent of clk.
- Half-period: H = ceil(N/2) = (N+1)>>1, computed at DIV_W+1 bits so N = 2^DIV_W-1 does not overflow.
- Boundary occurs at any rising edge where one of these holds:
  (a) ratio_q<2 (bypass);
  (b) cnt==ratio_q-1;
  (c) the first edge with i_en=1 after i_en=0 or after reset.
- At a boundary with i_en=1:
  - ratio_q<=i_div_ratio; cnt<=0; tick_q<=1.
  - div_q<=1 if i_div_ratio>=2, else div_q<=0.
- Non-boundary edge with i_en=1:
  - cnt<=cnt+1; tick_q<=0.
  - div_q<=((cnt+1) < H(ratio_q)).
- Any edge with i_en=0: cnt<=0, div_q<=0, tick_q<=0; ratio_q holds. Condition (c) then arms for the next i_en=1 edge.
- Duty cycle: high for H cycles, low for N-H cycles. Examples: N=8 gives 4/4; N=5 gives 3/2; N=3 gives 2/1; N=2 gives 1/1.
- o_clk:
  - if ratio_q>=2: o_clk = div_q (registered, no combinational path from clk);
  - if ratio_q<2: o_clk = clk & en_n.
  - en_n is captured on the falling edge so the gate only changes while clk is low.
- o_tick = tick_q:
  - divide mode: high during the first high-phase cycle of each period;
  - bypass: high every cycle while enabled.
- Ratio change mid-period: the current period completes at the old ratio, and the new ratio starts at the next boundary. i_div_ratio is sampled only at boundaries; between them it is don't-care.
- Glitch freedom on mode switch:
  - divide→bypass: the boundary follows a low phase, and the next clk high is the first bypass pulse.
  - bypass→divide: div_q rises at the same edge at which clk rises, so o_clk stays high with no runt pulse.
  - Minimum o_clk high or low width is always ≥ half a clk period.
- Enable drop mid-high-phase: o_clk goes low at the next rising edge. The truncated pulse is accepted; consumers gate on o_tick.
- Reset mid-operation: outputs go low immediately. After release, the first i_en=1 edge is a boundary.

Test Plan:
1. Reset, then i_en=1, i_div_ratio=8 → after the first edge, o_clk repeats 4 high/4 low; o_tick pulses every 8 clk cycles, aligned with each o_clk rise; o_ratio=8.
2. i_div_ratio=3, then 5, then 255 (DIV_W=8), each applied at a boundary → high/low of 2/1, 3/2, and 128/127; periods of 3, 5, and 255 cycles.
3. Running at N=8; change to 3 when cnt=2 → the current period still totals 8 cycles and o_ratio stays 8 until the boundary; afterwards 3-cycle periods and o_ratio=3.
4. i_div_ratio=1, then 0 → o_clk equals clk and o_tick is high every cycle. Switching 4→1→4 produces no pulse shorter than half a clk period (checked with $time on o_clk edges).
5. N=6, deassert i_en during the high phase → o_clk=0 at the next edge and stays 0, o_tick=0. Reassert → o_clk goes high at the first enabled edge, o_tick pulses, and full 3/3 periods resume.
6. Assert rst asynchronously mid-period at N=7 (between edges) → o_clk, o_tick, o_ratio all 0 without waiting for a clk edge. Release → normal operation from a fresh boundary.
